// File: rtl/delay_line_ctrl.sv
// Write/read sequencer for a circular sample RAM that produces a programmable sample delay.
// Each accepted sample is written at wptr and the matching delayed read is issued at wptr-offset.
module delay_line_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 9,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   output logic                     wr_en,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]    din,
   output logic                     rd_en,
   output logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic                     out_valid,
   output logic                     primed
);

   localparam int unsigned FillW = ADDRESS_WIDTH + 1;
   localparam logic [FillW-1:0] FillMax = {1'b1, {ADDRESS_WIDTH{1'b0}}};
   localparam logic [FillW-1:0] FillOne = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDRESS_WIDTH-1:0] off_q, off_d;
   logic [FillW-1:0]         fill_q, fill_d;
   logic [FillW-1:0]         eff;
   logic                     rd_valid_q, rd_valid_d;
   logic                     primed_d;
   logic                     off_change;
   logic                     load;
   logic                     hit;
   logic [ADDRESS_WIDTH-1:0] rd_ptr;

   always_comb begin
      off_change = (state_q != StIdle) && (offset != off_q);
      load       = off_change || ((state_q == StIdle) && in_valid);
      off_d      = load ? offset : off_q;
      // Offset 0 reads the slot being overwritten, i.e. a full-buffer delay.
      eff        = (off_d == '0) ? FillMax : {1'b0, off_d};

      fill_d = fill_q;
      if (load) begin
         fill_d = in_valid ? FillOne : '0;
      end else if (in_valid && (fill_q != FillMax)) begin
         fill_d = fill_q + FillOne;
      end
      hit = in_valid && (fill_d == eff);

      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) state_d = hit ? StRun : StFill;
         end
         StFill: begin
            if (off_change || hit) state_d = hit ? StRun : StFill;
         end
         StRun: begin
            if (off_change) state_d = hit ? StRun : StFill;
         end
         default: state_d = StIdle;
      endcase

      primed_d = (state_d == StRun);
      // A read is valid only if the buffer was already primed before this accept.
      rd_valid_d = in_valid && primed && !off_change;
      wptr_d     = in_valid ? wptr_q + 1'b1 : wptr_q;
      rd_ptr     = wptr_q - off_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         off_q      <= '0;
         fill_q     <= '0;
         rd_valid_q <= 1'b0;
         primed     <= 1'b0;
         out_valid  <= 1'b0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         din        <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         off_q      <= off_d;
         fill_q     <= fill_d;
         rd_valid_q <= rd_valid_d;
         primed     <= primed_d;
         out_valid  <= rd_valid_q;
         wr_en      <= in_valid;
         rd_en      <= in_valid;
         if (in_valid) begin
            wr_addr <= wptr_q;
            rd_addr <= rd_ptr;
            din     <= in_data;
         end
      end
   end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Write/read sequencer that drives both ports of the 512x8 sample RAM to implement a programmable sample delay for the signal generator.
- Accepts one incoming sample per strobe and writes it at a circular write pointer.
- Issues the matching delayed read at (write pointer - offset).
- Flags when RAM read data, one cycle later, is a valid delayed sample.

Parameters:
- ADDRESS_WIDTH, 9: RAM address width; the buffer holds 2**ADDRESS_WIDTH samples.
- DATA_WIDTH, 8: sample width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample strobe; one sample is accepted per cycle it is high.
- in_data  input  DATA_WIDTH  incoming sample.
- offset  input  ADDRESS_WIDTH  requested delay in samples.
- wr_en  output  1  RAM write enable.
- wr_addr  output  ADDRESS_WIDTH  RAM write address.
- din  output  DATA_WIDTH  RAM write data.
- rd_en  output  1  RAM read enable.
- rd_addr  output  ADDRESS_WIDTH  RAM read address.
- out_valid  output  1  high in the cycle RAM doutDelayed holds a valid delayed sample.
- primed  output  1  high once offset samples have been buffered since the last offset change.

Behaviour:
- Reset is asynchronous, active-low: clk is the only clock and rst_n the only reset; asserting rst_n low clears all state immediately, without waiting for a clock edge.
- Reset values:
  - wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, din=0, out_valid=0, primed=0.
  - Internal wptr=0, fill_cnt=0, off_q=0, state=IDLE.
- All outputs are registered.
- Accept cycle t (in_valid=1):
  - At edge t+1: wr_en=1, wr_addr=wptr, din=in_data, rd_en=1, rd_addr=(wptr-off_q) mod 2**ADDRESS_WIDTH.
  - Then wptr increments mod 2**ADDRESS_WIDTH, wrapping 511->0.
- No accept in cycle t: wr_en=0 and rd_en=0 at t+1; wr_addr, rd_addr and din hold their values.
- Read latency: the RAM registers read data, so out_valid is a 1-cycle delayed copy of (rd_en AND primed at issue time). It is high at edge t+2, aligned with doutDelayed.
- Read-during-write at the same address returns the old contents. Therefore offset=0 gives an effective delay of 2**ADDRESS_WIDTH samples. This is intended behaviour.
- fill_cnt is ADDRESS_WIDTH+1 bits wide and saturates at 2**ADDRESS_WIDTH.
- State machine:
  - IDLE: entered from reset. First accept: off_q<=offset, fill_cnt<=1, go FILL. If offset==1 go directly to RUN instead.
  - FILL: each accept increments fill_cnt. Go to RUN on the accept where fill_cnt reaches eff, where eff=off_q (or 2**ADDRESS_WIDTH when off_q=0).
  - RUN: primed=1; every accept produces out_valid two cycles later.
- Offset change: when offset != off_q in FILL or RUN, regardless of in_valid:
  - off_q<=offset, fill_cnt<=0, primed<=0, go to FILL.
  - wptr is not reset.
  - A read already in flight still completes RAM-side, but out_valid follows primed at its issue time.
  - Offset change and accept in the same cycle: the sample is written and counted as fill_cnt=1 under the new offset. Its read uses the new offset and is not valid.
- Reset mid-operation: everything returns to reset values and the pipeline is discarded. RAM contents are not cleared. After reset, samples are invalid until refilled.
- Back-to-back in_valid every cycle is supported at full throughput with no stall; there is no backpressure.

Test Plan:
- Reset, offset=4, feed samples 0x10,0x11,... on consecutive cycles:
  - wr_addr runs 0,1,2...
  - rd_addr = wr_addr-4 mod 512: 508,509,510,511,0...
  - primed rises on the 4th accept.
  - The first out_valid lands 2 cycles after the 5th accept, and doutDelayed=0x10.
- Sparse strobes (in_valid every 3rd cycle), offset=2:
  - wr_en/rd_en pulse only one cycle after each strobe.
  - out_valid pulses align with doutDelayed = the sample 2 accepts earlier.
- Wrap: feed 600 samples with offset=100:
  - wr_addr wraps 511->0.
  - At wr_addr=50, rd_addr=462, and the output equals the sample written 100 accepts earlier.
- Offset change in RUN (4->8 mid-stream, simultaneous with an accept):
  - primed drops the next cycle and out_valid is suppressed.
  - primed returns after 8 accepts under the new offset, and outputs carry the correct 8-sample delay.
- offset=0: no out_valid for the first 512 accepts; afterwards output = the sample from 512 accepts earlier.
- Assert rst_n low asynchronously mid-stream (between edges):
  - All outputs are 0 immediately.
  - After release, behaviour matches a fresh start with wr_addr=0.
